// File: rtl/dds_wave_ctrl.sv
// dds_wave_ctrl -- DDS playback controller for a 4096-entry waveform RAM.
//
// A phase accumulator steps by fword each RUN cycle. The top 10 phase bits
// plus pword index one of three 1024-entry table segments, selected by
// wave_sel: 0 = sine, 1 = triangle, 2 = square, 3 = sine. Segment 3 of the
// RAM (0xC00..0xFFF) is never read. RAM reads have a one-cycle latency.
// A sample reaches wave_out two cycles after its address is registered.
//
// Optional feature macro: DDS_WAVE_LOAD_EN
//   When defined, the table can be written in IDLE through the
//   load_valid/load_ready handshake. When undefined, load_ready, ram_wea
//   and ram_din are tied 0, the load inputs are ignored, and the table
//   content comes only from RAM initialisation.
//
// Ports
//   clka             clock, rising edge
//   rst_n            synchronous active-low reset
//   start / stop     one-cycle playback control pulses (stop wins a tie)
//   fword            frequency tuning word (PHASE_W bits)
//   pword            phase offset in table entries (10 bits)
//   wave_sel         segment select
//   load_valid/ready waveform-load handshake
//   load_addr/data   write address / write data for a load beat
//   ram_ena/wea/addr/din  registered RAM port drive
//   ram_dout         RAM read data
//   wave_out/valid   registered output sample and its qualifier
//   busy             high in RUN and DRAIN

`ifndef WIDTH
`define WIDTH 16
`endif

module dds_wave_ctrl #(
  parameter int unsigned WIDTH   = `WIDTH,
  parameter int unsigned PHASE_W = 32
) (
  input  logic               clka,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [PHASE_W-1:0] fword,
  input  logic [9:0]         pword,
  input  logic [1:0]         wave_sel,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [11:0]        load_addr,
  input  logic [WIDTH-1:0]   load_data,
  output logic               ram_ena,
  output logic               ram_wea,
  output logic [11:0]        ram_addr,
  output logic [WIDTH-1:0]   ram_din,
  input  logic [WIDTH-1:0]   ram_dout,
  output logic [WIDTH-1:0]   wave_out,
  output logic               wave_valid,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t             r_state;
  logic [PHASE_W-1:0] r_acc;
  logic               r_drain_cnt;
  logic               r_rd_pend;
  logic               r_ram_ena;
  logic [11:0]        r_ram_addr;
  logic [WIDTH-1:0]   r_wave_out;
  logic               r_wave_valid;
  logic               r_busy;

  logic [9:0]         w_idx;
  logic [1:0]         w_seg;

  // Table index wraps modulo 1024 inside the selected segment.
  assign w_idx = r_acc[PHASE_W-1 -: 10] + pword;
  assign w_seg = (wave_sel == 2'd3) ? 2'd0 : wave_sel;

`ifdef DDS_WAVE_LOAD_EN
  logic             r_ram_wea;
  logic [WIDTH-1:0] r_ram_din;
  logic             r_load_ready;
  logic             r_start_pend;
  logic             w_load_beat;

  assign w_load_beat = load_valid && r_load_ready;
  assign ram_wea     = r_ram_wea;
  assign ram_din     = r_ram_din;
  assign load_ready  = r_load_ready;
`else
  logic w_unused_load;

  assign w_unused_load = ^{load_valid, load_addr, load_data};
  assign ram_wea       = 1'b0;
  assign ram_din       = '0;
  assign load_ready    = 1'b0;
`endif

  assign ram_ena    = r_ram_ena;
  assign ram_addr   = r_ram_addr;
  assign wave_out   = r_wave_out;
  assign wave_valid = r_wave_valid;
  assign busy       = r_busy;

  always_ff @(posedge clka) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_drain_cnt  <= 1'b0;
      r_rd_pend    <= 1'b0;
      r_ram_ena    <= 1'b0;
      r_ram_addr   <= '0;
      r_wave_out   <= '0;
      r_wave_valid <= 1'b0;
      r_busy       <= 1'b0;
`ifdef DDS_WAVE_LOAD_EN
      r_ram_wea    <= 1'b0;
      r_ram_din    <= '0;
      r_load_ready <= 1'b1;
      r_start_pend <= 1'b0;
`endif
    end else begin
      // Two-stage read pipeline: address -> ram_dout -> wave_out.
      r_rd_pend    <= r_ram_ena && !ram_wea;
      r_wave_valid <= r_rd_pend;
      if (r_rd_pend) begin
        r_wave_out <= ram_dout;
      end
      r_ram_ena <= 1'b0;
`ifdef DDS_WAVE_LOAD_EN
      r_ram_wea <= 1'b0;
`endif

      case (r_state)
        S_IDLE: begin
`ifdef DDS_WAVE_LOAD_EN
          if (r_start_pend) begin
            r_start_pend <= 1'b0;
            r_state      <= S_RUN;
            r_acc        <= '0;
            r_busy       <= 1'b1;
          end else begin
            if (w_load_beat) begin
              r_ram_ena  <= 1'b1;
              r_ram_wea  <= 1'b1;
              r_ram_addr <= load_addr;
              r_ram_din  <= load_data;
            end
            if (start && !stop) begin
              // A start that collides with a load beat waits one cycle so
              // the write owns the RAM port before the first read.
              r_load_ready <= 1'b0;
              if (w_load_beat) begin
                r_start_pend <= 1'b1;
              end else begin
                r_state <= S_RUN;
                r_acc   <= '0;
                r_busy  <= 1'b1;
              end
            end
          end
`else
          if (start && !stop) begin
            r_state <= S_RUN;
            r_acc   <= '0;
            r_busy  <= 1'b1;
          end
`endif
        end

        S_RUN: begin
          if (stop) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= 1'b0;
          end else begin
            r_ram_ena  <= 1'b1;
            r_ram_addr <= {w_seg, w_idx};
            r_acc      <= r_acc + fword;
          end
        end

        S_DRAIN: begin
          if (r_drain_cnt) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
`ifdef DDS_WAVE_LOAD_EN
            r_load_ready <= 1'b1;
`endif
          end else begin
            r_drain_cnt <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
